// File: rtl/fp_div.sv
// fp_div: iterative IEEE-754 binary32 divider, fp_Z = fp_X / fp_Y.
// One quotient bit per clock (restoring), fixed 27-clock latency from the accepting edge to done.
// Subnormal inputs are read as signed zero; results never go subnormal (flushed, udrf=1).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             request, sampled only while busy=0
//   r_mode[2:0]       100 nearest-even, 000 toward zero, 010 toward +inf, 001 toward -inf
//   fp_X, fp_Y        dividend / divisor, sampled with start
//   busy              operation in flight
//   done              one-cycle pulse, fp_Z and flags valid
//   fp_Z              quotient, held until the next done
//   ovrf, udrf, dvz   overflow, underflow (flushed), finite nonzero divided by zero
module fp_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  r_mode,
    input  logic [31:0] fp_X,
    input  logic [31:0] fp_Y,
    output logic        busy,
    output logic        done,
    output logic [31:0] fp_Z,
    output logic        ovrf,
    output logic        udrf,
    output logic        dvz
);

    typedef enum logic [1:0] {StIdle, StDiv, StRnd} state_e;

    state_e             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [24:0]        rem_q, rem_d;
    logic [23:0]        dvs_q, dvs_d;
    logic [25:0]        quo_q, quo_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [2:0]         mode_q, mode_d;
    logic               spec_q, spec_d;
    logic [31:0]        spec_z_q, spec_z_d;
    logic               spec_dvz_q, spec_dvz_d;
    logic [31:0]        fp_z_q, fp_z_d;
    logic               ovrf_q, ovrf_d, udrf_q, udrf_d, dvz_q, dvz_d, done_q, done_d;

    // Operand classification at latch time
    logic [7:0] x_exp, y_exp;
    logic       x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, new_sign;
    logic       hit;
    logic [31:0] hit_z;
    logic       hit_dvz;

    assign x_exp    = fp_X[30:23];
    assign y_exp    = fp_Y[30:23];
    assign x_zero   = (x_exp == 8'h00);
    assign y_zero   = (y_exp == 8'h00);
    assign x_inf    = (x_exp == 8'hff) && (fp_X[22:0] == 23'd0);
    assign y_inf    = (y_exp == 8'hff) && (fp_Y[22:0] == 23'd0);
    assign x_nan    = (x_exp == 8'hff) && (fp_X[22:0] != 23'd0);
    assign y_nan    = (y_exp == 8'hff) && (fp_Y[22:0] != 23'd0);
    assign new_sign = fp_X[31] ^ fp_Y[31];

    always_comb begin
        hit     = 1'b1;
        hit_z   = 32'd0;
        hit_dvz = 1'b0;
        if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
            hit_z = 32'h7fc0_0000;
        end else if (x_inf) begin
            hit_z = {new_sign, 8'hff, 23'd0};
        end else if (y_zero) begin
            hit_z   = {new_sign, 8'hff, 23'd0};
            hit_dvz = 1'b1;
        end else if (y_inf || x_zero) begin
            hit_z = {new_sign, 31'd0};
        end else begin
            hit = 1'b0;
        end
    end

    // Restoring step: partial remainder stays below 2*divisor, so 25 bits suffice
    logic        step_ge;
    logic [24:0] rem_sub, rem_next;

    assign step_ge  = (rem_q >= {1'b0, dvs_q});
    assign rem_sub  = rem_q - {1'b0, dvs_q};
    assign rem_next = step_ge ? {rem_sub[23:0], 1'b0} : {rem_q[23:0], 1'b0};

    // Normalise, round, range-check
    logic               rm_rz, rm_ru, rm_rd;
    logic [23:0]        mant, mant_r;
    logic [24:0]        mant_inc;
    logic               guard, sticky, round_up, away;
    logic signed [9:0]  e_pre, e_r;
    logic [31:0]        rnd_z;
    logic               rnd_ovf, rnd_unf;

    assign rm_rz = (mode_q == 3'b000);
    assign rm_ru = (mode_q == 3'b010);
    assign rm_rd = (mode_q == 3'b001);

    always_comb begin
        if (quo_q[25]) begin
            mant   = quo_q[25:2];
            guard  = quo_q[1];
            sticky = quo_q[0] | (rem_q != 25'd0);
            e_pre  = exp_q;
        end else begin
            mant   = quo_q[24:1];
            guard  = quo_q[0];
            sticky = (rem_q != 25'd0);
            e_pre  = exp_q - 10'sd1;
        end

        if (rm_rz)      round_up = 1'b0;
        else if (rm_ru) round_up = ~sign_q & (guard | sticky);
        else if (rm_rd) round_up = sign_q & (guard | sticky);
        else            round_up = guard & (sticky | mant[0]);

        mant_inc = {1'b0, mant} + {24'd0, round_up};
        if (mant_inc[24]) begin
            mant_r = 24'h80_0000;
            e_r    = e_pre + 10'sd1;
        end else begin
            mant_r = mant_inc[23:0];
            e_r    = e_pre;
        end

        // Overflow goes to inf only when the mode rounds away from zero for this sign
        if (rm_rz)      away = 1'b0;
        else if (rm_ru) away = ~sign_q;
        else if (rm_rd) away = sign_q;
        else            away = 1'b1;

        rnd_ovf = (e_r >= 10'sd255);
        rnd_unf = (e_r <= 10'sd0);
        if (rnd_ovf)      rnd_z = away ? {sign_q, 8'hff, 23'd0} : {sign_q, 31'h7f7f_ffff};
        else if (rnd_unf) rnd_z = {sign_q, 31'd0};
        else              rnd_z = {sign_q, e_r[7:0], mant_r[22:0]};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        quo_d      = quo_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        mode_d     = mode_q;
        spec_d     = spec_q;
        spec_z_d   = spec_z_q;
        spec_dvz_d = spec_dvz_q;
        fp_z_d     = fp_z_q;
        ovrf_d     = ovrf_q;
        udrf_d     = udrf_q;
        dvz_d      = dvz_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cnt_d      = 5'd0;
                    rem_d      = {2'b01, fp_X[22:0]};
                    dvs_d      = {1'b1, fp_Y[22:0]};
                    quo_d      = 26'd0;
                    sign_d     = new_sign;
                    exp_d      = {2'b00, x_exp} - {2'b00, y_exp} + 10'sd127;
                    mode_d     = r_mode;
                    spec_d     = hit;
                    spec_z_d   = hit_z;
                    spec_dvz_d = hit_dvz;
                    state_d    = StDiv;
                end
            end
            StDiv: begin
                quo_d = {quo_q[24:0], step_ge};
                rem_d = rem_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd25) state_d = StRnd;
            end
            StRnd: begin
                done_d  = 1'b1;
                state_d = StIdle;
                if (spec_q) begin
                    fp_z_d = spec_z_q;
                    ovrf_d = 1'b0;
                    udrf_d = 1'b0;
                    dvz_d  = spec_dvz_q;
                end else begin
                    fp_z_d = rnd_z;
                    ovrf_d = rnd_ovf;
                    udrf_d = rnd_unf;
                    dvz_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 5'd0;
            rem_q      <= 25'd0;
            dvs_q      <= 24'd0;
            quo_q      <= 26'd0;
            sign_q     <= 1'b0;
            exp_q      <= 10'sd0;
            mode_q     <= 3'd0;
            spec_q     <= 1'b0;
            spec_z_q   <= 32'd0;
            spec_dvz_q <= 1'b0;
            fp_z_q     <= 32'd0;
            ovrf_q     <= 1'b0;
            udrf_q     <= 1'b0;
            dvz_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            quo_q      <= quo_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            mode_q     <= mode_d;
            spec_q     <= spec_d;
            spec_z_q   <= spec_z_d;
            spec_dvz_q <= spec_dvz_d;
            fp_z_q     <= fp_z_d;
            ovrf_q     <= ovrf_d;
            udrf_q     <= udrf_d;
            dvz_q      <= dvz_d;
            done_q     <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign fp_Z = fp_z_q;
    assign ovrf = ovrf_q;
    assign udrf = udrf_q;
    assign dvz  = dvz_q;

endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: directed vectors pinned by hand-computed literals, a
// value-level reference model, host floating-point cross-check on random operands, and a
// monitor that checks every done pulse (value, flags, latency) against a queue of expectations.
module tb_fp_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  r_mode = 3'd0;
    logic [31:0] fp_X = 32'd0;
    logic [31:0] fp_Y = 32'd0;
    logic        busy, done, ovrf, udrf, dvz;
    logic [31:0] fp_Z;

    fp_div dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .r_mode (r_mode),
        .fp_X   (fp_X),
        .fp_Y   (fp_Y),
        .busy   (busy),
        .done   (done),
        .fp_Z   (fp_Z),
        .ovrf   (ovrf),
        .udrf   (udrf),
        .dvz    (dvz)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] z;
        logic [2:0]  flags;   // {ovrf, udrf, dvz}
        int          c;
    } exp_t;
    exp_t expq[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Reference model: exact long-integer quotient of the significands, then round.
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  input logic [2:0] m, output logic [31:0] z,
                                  output logic [2:0] flags);
        logic       s;
        int         ex, ey, e;
        logic [63:0] num, den, q, r, mant;
        logic       g, st, up, xnan, ynan, xinf, yinf, xz, yz, away;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        xnan = (ex == 255) && (x[22:0] != 0);
        ynan = (ey == 255) && (y[22:0] != 0);
        xinf = (ex == 255) && (x[22:0] == 0);
        yinf = (ey == 255) && (y[22:0] == 0);
        xz = (ex == 0);
        yz = (ey == 0);
        flags = 3'b000;
        if (xnan || ynan || (xz && yz) || (xinf && yinf)) begin
            z = 32'h7fc0_0000;
        end else if (xinf) begin
            z = {s, 8'hff, 23'd0};
        end else if (yz) begin
            z = {s, 8'hff, 23'd0};
            flags = 3'b001;
        end else if (yinf || xz) begin
            z = {s, 31'd0};
        end else begin
            num = {40'd1, x[22:0]} << 40;   // 1.fx * 2^63
            den = {40'd1, y[22:0]};
            q = num / den;
            r = num % den;
            e = ex - ey + 127;
            if (q >= (64'd1 << 40)) begin
                mant = q >> 17;
                g    = q[16];
                st   = (q[15:0] != 0) || (r != 0);
            end else begin
                mant = q >> 16;
                g    = q[15];
                st   = (q[14:0] != 0) || (r != 0);
                e    = e - 1;
            end
            case (m)
                3'b000:  up = 1'b0;
                3'b010:  up = !s && (g || st);
                3'b001:  up = s && (g || st);
                default: up = g && (st || mant[0]);
            endcase
            case (m)
                3'b000:  away = 1'b0;
                3'b010:  away = !s;
                3'b001:  away = s;
                default: away = 1'b1;
            endcase
            mant = mant + 64'(up);
            if (mant == (64'd1 << 24)) begin
                mant = 64'd1 << 23;
                e    = e + 1;
            end
            if (e >= 255) begin
                z = away ? {s, 8'hff, 23'd0} : {s, 31'h7f7f_ffff};
                flags = 3'b100;
            end else if (e <= 0) begin
                z = {s, 31'd0};
                flags = 3'b010;
            end else begin
                z = {s, 8'(e), mant[22:0]};
            end
        end
    endfunction

    function automatic real to_real(input logic [31:0] b);
        real r;
        r = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (real'(int'(b[30:23])) - 127.0));
        return b[31] ? -r : r;
    endfunction

    // Host quotient in double, rounded to nearest-even binary32 (normal range only)
    function automatic logic [31:0] host_div(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] b;
        logic [24:0] mnt;
        int          e8;
        b   = $realtobits(to_real(x) / to_real(y));
        e8  = int'(b[62:52]) - 1023 + 127;
        mnt = {2'b01, b[51:29]};
        if (b[28] && ((b[27:0] != 0) || mnt[0])) mnt = mnt + 25'd1;
        if (mnt[24]) begin
            mnt = mnt >> 1;
            e8  = e8 + 1;
        end
        return {b[63], 8'(e8), mnt[22:0]};
    endfunction

    // Compare process: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin : mon
            exp_t e;
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1, want no done");
            end else begin
                e = expq.pop_front();
                check32("fp_Z", fp_Z, e.z);
                check32("flags_ovrf_udrf_dvz", {29'd0, ovrf, udrf, dvz}, {29'd0, e.flags});
                check32("latency", 32'(cyc - e.c), 32'd27);
                check32("busy_in_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
        exp_t e;
        model(x, y, m, e.z, e.flags);
        fp_X   = x;
        fp_Y   = y;
        r_mode = m;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.c = cyc;
        expq.push_back(e);
        check32("busy_after_start", {31'd0, busy}, 32'd1);
        // Scramble inputs: the latched operands alone must decide the result
        fp_X   = $urandom;
        fp_Y   = $urandom;
        r_mode = 3'($urandom);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: got no done in 40 cycles, want done at 27");
        end
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
        issue(x, y, m);
        wait_done();
    endtask

    // Pin the model against a hand-computed literal, then run the vector on the DUT
    task automatic pin(input string name, input logic [31:0] x, input logic [31:0] y,
                       input logic [2:0] m, input logic [31:0] want_z,
                       input logic [2:0] want_flags);
        logic [31:0] z;
        logic [2:0]  f;
        model(x, y, m, z, f);
        check32({"model_z_", name}, z, want_z);
        check32({"model_flags_", name}, {29'd0, f}, {29'd0, want_flags});
        run_op(x, y, m);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] x, y, mz;
        logic [2:0]  mf;

        repeat (3) @(negedge clk);
        check32("reset_busy", {31'd0, busy}, 32'd0);
        check32("reset_done", {31'd0, done}, 32'd0);
        check32("reset_fp_Z", fp_Z, 32'd0);
        check32("reset_flags", {29'd0, ovrf, udrf, dvz}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        pin("6div2",       32'h40c0_0000, 32'h4000_0000, 3'b100, 32'h4040_0000, 3'b000);
        pin("third_rne",   32'h3f80_0000, 32'h4040_0000, 3'b100, 32'h3eaa_aaab, 3'b000);
        pin("third_rz",    32'h3f80_0000, 32'h4040_0000, 3'b000, 32'h3eaa_aaaa, 3'b000);
        pin("third_rd",    32'h3f80_0000, 32'h4040_0000, 3'b001, 32'h3eaa_aaaa, 3'b000);
        pin("third_ru",    32'h3f80_0000, 32'h4040_0000, 3'b010, 32'h3eaa_aaab, 3'b000);
        pin("nthird_rd",   32'hbf80_0000, 32'h4040_0000, 3'b001, 32'hbeaa_aaab, 3'b000);
        pin("ovf_rne",     32'h7f00_0000, 32'h0080_0000, 3'b100, 32'h7f80_0000, 3'b100);
        pin("ovf_rz",      32'h7f00_0000, 32'h0080_0000, 3'b000, 32'h7f7f_ffff, 3'b100);
        pin("ovf_ru",      32'h7f00_0000, 32'h0080_0000, 3'b010, 32'h7f80_0000, 3'b100);
        pin("ovf_rd",      32'h7f00_0000, 32'h0080_0000, 3'b001, 32'h7f7f_ffff, 3'b100);
        pin("novf_rd",     32'hff00_0000, 32'h0080_0000, 3'b001, 32'hff80_0000, 3'b100);
        pin("unf_pos",     32'h0080_0000, 32'h4000_0000, 3'b100, 32'h0000_0000, 3'b010);
        pin("unf_neg",     32'h8080_0000, 32'h4000_0000, 3'b100, 32'h8000_0000, 3'b010);
        pin("zero_zero",   32'h0000_0000, 32'h0000_0000, 3'b100, 32'h7fc0_0000, 3'b000);
        pin("one_zero",    32'h3f80_0000, 32'h0000_0000, 3'b100, 32'h7f80_0000, 3'b001);
        pin("mone_inf",    32'hbf80_0000, 32'h7f80_0000, 3'b100, 32'h8000_0000, 3'b000);
        pin("nan_one",     32'h7fc0_0000, 32'h3f80_0000, 3'b100, 32'h7fc0_0000, 3'b000);
        pin("inf_inf",     32'h7f80_0000, 32'hff80_0000, 3'b100, 32'h7fc0_0000, 3'b000);
        pin("inf_two",     32'h7f80_0000, 32'hc000_0000, 3'b100, 32'hff80_0000, 3'b000);
        pin("zero_two",    32'h8000_0000, 32'h4000_0000, 3'b100, 32'h8000_0000, 3'b000);
        pin("subn_zero",   32'h0000_0001, 32'h0040_0000, 3'b100, 32'h7fc0_0000, 3'b000);

        // start re-pulsed mid-operation with different operands must be ignored
        issue(32'h40c0_0000, 32'h4000_0000, 3'b100);
        repeat (4) @(negedge clk);
        fp_X   = 32'h3f80_0000;
        fp_Y   = 32'h4040_0000;
        r_mode = 3'b000;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (35) @(negedge clk);

        // reset mid-operation aborts with no done afterwards
        issue(32'h3f80_0000, 32'h4040_0000, 3'b100);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check32("abort_busy", {31'd0, busy}, 32'd0);
        check32("abort_done", {31'd0, done}, 32'd0);
        check32("abort_fp_Z", fp_Z, 32'd0);
        check32("abort_flags", {29'd0, ovrf, udrf, dvz}, 32'd0);
        expq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // random normal operands, nearest-even, against the host quotient
        for (int i = 0; i < 100; i++) begin
            x = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
            y = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
            model(x, y, 3'b100, mz, mf);
            check32("model_vs_host", mz, host_div(x, y));
            run_op(x, y, 3'b100);
        end

        repeat (5) @(negedge clk);
        check32("queue_drained", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
